// File: rtl/spi_reg_master_if.sv
// Command/response handshake between a register client and spi_reg_master.
interface spi_reg_master_if #(
    parameter int ADDR_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_wdata;
    logic              rsp_valid;
    logic [7:0]        rsp_rdata;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/spi_reg_master.sv
// SPI mode-0 register master: one 16-bit frame per command
// ({write, addr[6:0], data}), MSB first, with a fixed chip-select gap.
module spi_reg_master #(
    parameter int ADDR_W  = 4,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_reg_master_if.slave  bus,
    output logic             busy,
    output logic             spi_cs_n,
    output logic             spi_clk,
    output logic             spi_mosi,
    input  logic             spi_miso
);
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

    state_t      state, state_nxt;
    logic [7:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic [15:0] tx_shift;
    logic [7:0]  rx_shift;
    logic        is_write;
    logic        cmd_ready;
    logic        accept;
    logic        phase_last;
    logic        gap_last;
    logic [6:0]  addr7;
    logic [15:0] frame;

    assign phase_last    = (div_cnt == 8'(CLK_DIV - 1));
    assign gap_last      = (div_cnt == 8'(CS_GAP - 1));
    assign bus.cmd_ready = cmd_ready;

    // Frame image built from the command fields presented this cycle.
    always_comb begin
        addr7               = '0;
        addr7[ADDR_W-1:0]   = bus.cmd_addr;
        frame               = {bus.cmd_write, addr7, bus.cmd_write ? bus.cmd_wdata : 8'h00};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and pin decode; all SPI pins follow the current state.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        busy      = 1'b1;
        spi_cs_n  = 1'b0;
        spi_clk   = 1'b0;
        spi_mosi  = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                spi_cs_n  = 1'b1;
                cmd_ready = rst_n;
                if (bus.cmd_valid && rst_n) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                spi_mosi = tx_shift[15];
                if (phase_last) state_nxt = HIGH;
            end
            HIGH: begin
                spi_clk  = 1'b1;
                spi_mosi = tx_shift[15];
                if (phase_last) state_nxt = (bit_cnt == 4'd0) ? HOLD : LOW;
            end
            LOW: begin
                spi_mosi = tx_shift[15];
                if (phase_last) state_nxt = HIGH;
            end
            HOLD: begin
                if (phase_last) state_nxt = GAP;
            end
            GAP: begin
                spi_cs_n = 1'b1;
                if (gap_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Divider/bit counters, shift registers and response generation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt       <= '0;
            bit_cnt       <= '0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            is_write      <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            // Every phase ends in a different state, so a state change restarts the divider.
            if (state == IDLE || state != state_nxt) div_cnt <= '0;
            else                                     div_cnt <= div_cnt + 8'd1;
            if (accept) begin
                tx_shift <= frame;
                bit_cnt  <= 4'd15;
                is_write <= bus.cmd_write;
                rx_shift <= '0;
            end
            if (state == HIGH && phase_last) begin
                // Only the last eight samples survive, so address-phase bits fall out.
                rx_shift <= {rx_shift[6:0], spi_miso};
                if (bit_cnt != 4'd0) begin
                    tx_shift <= {tx_shift[14:0], 1'b0};
                    bit_cnt  <= bit_cnt - 4'd1;
                end
            end
            if (state == HOLD && phase_last) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_rdata <= is_write ? 8'h00 : rx_shift;
            end
        end
    end
endmodule
